// File: rtl/servile_mux_pkg.sv
// Shared types and helpers for the servile Wishbone router.
// Optional slave timeout is enabled with SERVILE_MUX_TIMEOUT_EN.
package servile_mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        RESP = 2'd2
    } mux_state_t;

    localparam logic [31:0] DEFAULT_ERR_RDT = 32'hBADC0DE5;

    function automatic logic slot_valid(input int slot, input int num_slaves);
        return slot < num_slaves;
    endfunction

endpackage

// File: rtl/servile_mux_decode.sv
// Combinational address decode: top SEL_W address bits select the slave slot.
module servile_mux_decode
    import servile_mux_pkg::*;
#(
    parameter int NUM_SLAVES = 2,
    parameter int SEL_W      = 2
) (
    input  logic [31:0]      adr,
    output logic [SEL_W-1:0] slot,
    output logic             valid
);

    logic unused_low_adr;

    assign slot           = adr[31:32-SEL_W];
    assign valid          = slot_valid(int'(32'(slot)), NUM_SLAVES);
    assign unused_low_adr = ^adr[31-SEL_W:0];

endmodule

// File: rtl/servile_mux_n.sv
// Registered Wishbone router from the servile data port to NUM_SLAVES slaves.
// Define SERVILE_MUX_TIMEOUT_EN to abort slaves that do not ack within TIMEOUT cycles.
module servile_mux_n
    import servile_mux_pkg::*;
#(
    parameter int          NUM_SLAVES = 2,
    parameter int          SEL_W      = 2,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_RDT    = DEFAULT_ERR_RDT
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [31:0]              i_wb_cpu_adr,
    input  logic [31:0]              i_wb_cpu_dat,
    input  logic [3:0]               i_wb_cpu_sel,
    input  logic                     i_wb_cpu_we,
    input  logic                     i_wb_cpu_stb,
    output logic [31:0]              o_wb_cpu_rdt,
    output logic                     o_wb_cpu_ack,
    output logic                     o_wb_cpu_err,
    output logic [31:0]              o_wb_slv_adr,
    output logic [31:0]              o_wb_slv_dat,
    output logic [3:0]               o_wb_slv_sel,
    output logic                     o_wb_slv_we,
    output logic [NUM_SLAVES-1:0]    o_wb_slv_stb,
    input  logic [32*NUM_SLAVES-1:0] i_wb_slv_rdt,
    input  logic [NUM_SLAVES-1:0]    i_wb_slv_ack
);

    mux_state_t              state_q;
    logic [SEL_W-1:0]        slot_q;
    logic [SEL_W-1:0]        dec_slot;
    logic                    dec_valid;
    logic [NUM_SLAVES-1:0]   dec_onehot;
    logic                    ack_hit;
    logic [31:0]             rdt_hit;
    logic                    to_expire;

    servile_mux_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_W      (SEL_W)
    ) u_decode (
        .adr   (i_wb_cpu_adr),
        .slot  (dec_slot),
        .valid (dec_valid)
    );

    // NOTE: every output of an always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        dec_onehot = '0;
        ack_hit    = 1'b0;
        rdt_hit    = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (dec_slot == SEL_W'(k)) dec_onehot[k] = 1'b1;
            if (slot_q == SEL_W'(k)) begin
                ack_hit = i_wb_slv_ack[k];
                rdt_hit = i_wb_slv_rdt[32*k +: 32];
            end
        end
    end

`ifdef SERVILE_MUX_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt;

    // Expiry fires on the FWD cycle in which the counter would reach TIMEOUT.
    assign to_expire = (to_cnt == CNT_W'(TIMEOUT - 1));
`else
    localparam int unused_timeout = TIMEOUT;
    assign to_expire = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            o_wb_cpu_rdt <= '0;
            o_wb_cpu_ack <= 1'b0;
            o_wb_cpu_err <= 1'b0;
            o_wb_slv_adr <= '0;
            o_wb_slv_dat <= '0;
            o_wb_slv_sel <= '0;
            o_wb_slv_we  <= 1'b0;
            o_wb_slv_stb <= '0;
`ifdef SERVILE_MUX_TIMEOUT_EN
            to_cnt       <= '0;
`endif
        end else begin
            o_wb_cpu_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_wb_cpu_stb) begin
                        o_wb_slv_adr <= i_wb_cpu_adr;
                        o_wb_slv_dat <= i_wb_cpu_dat;
                        o_wb_slv_sel <= i_wb_cpu_sel;
                        o_wb_slv_we  <= i_wb_cpu_we;
                        slot_q       <= dec_slot;
                        if (dec_valid) begin
                            state_q      <= FWD;
                            o_wb_slv_stb <= dec_onehot;
`ifdef SERVILE_MUX_TIMEOUT_EN
                            to_cnt       <= '0;
`endif
                        end else begin
                            state_q      <= RESP;
                            o_wb_cpu_ack <= 1'b1;
                            o_wb_cpu_err <= 1'b1;
                            o_wb_cpu_rdt <= ERR_RDT;
                        end
                    end
                end
                FWD: begin
                    // A real ack beats a simultaneous timeout expiry.
                    if (ack_hit) begin
                        state_q      <= RESP;
                        o_wb_slv_stb <= '0;
                        o_wb_cpu_ack <= 1'b1;
                        o_wb_cpu_err <= 1'b0;
                        o_wb_cpu_rdt <= rdt_hit;
                    end else if (to_expire) begin
                        state_q      <= RESP;
                        o_wb_slv_stb <= '0;
                        o_wb_cpu_ack <= 1'b1;
                        o_wb_cpu_err <= 1'b1;
                        o_wb_cpu_rdt <= ERR_RDT;
                    end else begin
`ifdef SERVILE_MUX_TIMEOUT_EN
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q      <= IDLE;
                    o_wb_slv_stb <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servile_mux_n.sv
// Scoreboard bench for servile_mux_n: directed accesses push expected responses,
// a monitor pops and compares on every CPU ack. Timeout cases need SERVILE_MUX_TIMEOUT_EN.
module tb_servile_mux_n;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hBADC0DE5;

    typedef struct {
        logic [31:0] rdt;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_adr, cpu_dat;
    logic [3:0]  cpu_sel;
    logic        cpu_we, cpu_stb;
    logic [31:0] cpu_rdt;
    logic        cpu_ack, cpu_err;
    logic [31:0] slv_adr, slv_dat;
    logic [3:0]  slv_sel;
    logic        slv_we;
    logic [1:0]  slv_stb;
    logic [63:0] slv_rdt;
    logic [1:0]  slv_ack;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    servile_mux_n #(
        .NUM_SLAVES (2),
        .SEL_W      (2),
        .TIMEOUT    (TO),
        .ERR_RDT    (ERR)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_wb_cpu_adr (cpu_adr),
        .i_wb_cpu_dat (cpu_dat),
        .i_wb_cpu_sel (cpu_sel),
        .i_wb_cpu_we  (cpu_we),
        .i_wb_cpu_stb (cpu_stb),
        .o_wb_cpu_rdt (cpu_rdt),
        .o_wb_cpu_ack (cpu_ack),
        .o_wb_cpu_err (cpu_err),
        .o_wb_slv_adr (slv_adr),
        .o_wb_slv_dat (slv_dat),
        .o_wb_slv_sel (slv_sel),
        .o_wb_slv_we  (slv_we),
        .o_wb_slv_stb (slv_stb),
        .i_wb_slv_rdt (slv_rdt),
        .i_wb_slv_ack (slv_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every CPU ack must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cpu_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with rdt %h err %b, expected no ack", cpu_rdt, cpu_err);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                check("resp_rdt", cpu_rdt, e.rdt);
                check("resp_err", 32'(cpu_err), 32'(e.err));
            end
        end
    end

    // Starts on a negedge; ack_cycle is the cycle (strobe visible in cycle 1) in which
    // the addressed slave acks, 0 meaning never.
    task automatic access(input string name, input logic [31:0] adr, input logic [31:0] dat,
                          input logic we, input int ack_cycle, input logic [31:0] srdt,
                          input logic other_ack, input logic [31:0] exp_rdt, input logic exp_err);
        int   slot;
        int   resp_cycle;
        logic [1:0] exp_stb;
        resp_t e;
        slot    = int'(adr[31:30]);
        exp_stb = (slot == 0) ? 2'b01 : 2'b10;
        cpu_adr = adr;
        cpu_dat = dat;
        cpu_sel = 4'hF;
        cpu_we  = we;
        cpu_stb = 1'b1;
        slv_rdt = (slot == 1) ? {srdt, 32'hDEAD0000} : {32'hDEAD0001, srdt};
        e.rdt   = exp_rdt;
        e.err   = exp_err;
        exp_q.push_back(e);
        if (slot >= 2) begin
            @(negedge clk);
            check({name, "_no_stb"}, 32'(slv_stb), 32'd0);
            check({name, "_ack_cyc1"}, 32'(cpu_ack), 32'd1);
            cpu_stb = 1'b0;
            @(negedge clk);
            check({name, "_ack_single"}, 32'(cpu_ack), 32'd0);
            return;
        end
        resp_cycle = (ack_cycle > 0) ? ack_cycle + 1 : TO + 1;
        for (int c = 1; c < resp_cycle; c++) begin
            @(negedge clk);
            check({name, "_stb"}, 32'(slv_stb), 32'(exp_stb));
            check({name, "_no_early_ack"}, 32'(cpu_ack), 32'd0);
            if (c == 1) begin
                check({name, "_slv_adr"}, slv_adr, adr);
                check({name, "_slv_dat"}, slv_dat, dat);
                check({name, "_slv_we"}, 32'(slv_we), 32'(we));
                check({name, "_slv_sel"}, 32'(slv_sel), 32'hF);
            end
            slv_ack          = 2'b00;
            slv_ack[slot]    = (c == ack_cycle);
            slv_ack[1-slot]  = other_ack;
        end
        @(negedge clk);
        slv_ack = 2'b00;
        check({name, "_stb_drop"}, 32'(slv_stb), 32'd0);
        check({name, "_ack_latency"}, 32'(cpu_ack), 32'd1);
        cpu_stb = 1'b0;
        @(negedge clk);
        check({name, "_ack_single"}, 32'(cpu_ack), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        cpu_adr = '0;
        cpu_dat = '0;
        cpu_sel = '0;
        cpu_we  = 1'b0;
        cpu_stb = 1'b0;
        slv_rdt = '0;
        slv_ack = '0;

        repeat (2) @(negedge clk);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_cpu_err", 32'(cpu_err), 32'd0);
        check("rst_cpu_rdt", cpu_rdt, 32'd0);
        check("rst_slv_stb", 32'(slv_stb), 32'd0);
        check("rst_slv_adr", slv_adr, 32'd0);
        check("rst_slv_dat", slv_dat, 32'd0);
        check("rst_slv_sel", 32'(slv_sel), 32'd0);
        check("rst_slv_we", 32'(slv_we), 32'd0);

        // Stb already high across reset release.
        cpu_adr = 32'h0000_1000;
        cpu_stb = 1'b1;
        @(negedge clk);
        check("rst_hold_stb", 32'(slv_stb), 32'd0);
        rst_n = 1'b1;
        access("rel_rd0", 32'h0000_1000, 32'h0, 1'b0, 1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0);

        // Write slot 0, slave acks two cycles after its strobe; rdt captured on writes too.
        access("wr0", 32'h0000_1000, 32'h1234_5678, 1'b1, 3, 32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0);
        check("idle_rdt_hold", cpu_rdt, 32'h1111_2222);

        // Read slot 1 with slave 0 ack forced high throughout.
        access("rd1", 32'h4000_0000, 32'h0, 1'b0, 2, 32'hCAFE_BABE, 1'b1, 32'hCAFE_BABE, 1'b0);

        // Unmapped slots 3 and 2, back to back.
        access("unmap3", 32'hC000_0000, 32'h0, 1'b0, 0, 32'h0, 1'b0, ERR, 1'b1);
        access("unmap2", 32'h8000_0004, 32'h0, 1'b1, 0, 32'h0, 1'b0, ERR, 1'b1);
        check("unmap_rdt_hold", cpu_rdt, ERR);

        // Write to slot 1 with minimum latency; err returns to 0.
        access("wr1", 32'h4000_0010, 32'hA5A5_5A5A, 1'b1, 1, 32'h7777_8888, 1'b0, 32'h7777_8888, 1'b0);

`ifdef SERVILE_MUX_TIMEOUT_EN
        access("to_never", 32'h0000_2000, 32'h0, 1'b0, 0, 32'h1234_0000, 1'b0, ERR, 1'b1);
        access("to_ack4", 32'h0000_2000, 32'h0, 1'b0, TO, 32'h5555_AAAA, 1'b0, 32'h5555_AAAA, 1'b0);
`endif

        // Reset during FWD aborts with no ack; strobe falls asynchronously.
        cpu_adr = 32'h4000_0000;
        cpu_we  = 1'b0;
        cpu_stb = 1'b1;
        @(negedge clk);
        check("abort_stb_up", 32'(slv_stb), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("abort_stb_async", 32'(slv_stb), 32'd0);
        check("abort_no_ack", 32'(cpu_ack), 32'd0);
        cpu_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        access("post_abort", 32'h4000_0020, 32'h0, 1'b0, 2, 32'h0F0F_F0F0, 1'b0, 32'h0F0F_F0F0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
